// File: rtl/cmsdk_mcu_pin_mux_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmsdk_mcu_pin_mux_cfg : per-port pin mux, filtered input path and         |
// | break-before-make output switching.                        Rev 1.0        |
// +--------------------------------------------------------------------------+
module cmsdk_mcu_pin_mux_cfg #(
  parameter int PIN_WIDTH   = 16,
  parameter int NUM_ALT     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int BBM_CYCLES  = 2
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [2*PIN_WIDTH-1:0]         func_sel,
  input  logic [PIN_WIDTH-1:0]           gpio_out,
  input  logic [PIN_WIDTH-1:0]           gpio_outen,
  input  logic [NUM_ALT*PIN_WIDTH-1:0]   alt_out,
  input  logic [NUM_ALT*PIN_WIDTH-1:0]   alt_outen,
  output logic [PIN_WIDTH-1:0]           pin_in,
  output logic [PIN_WIDTH-1:0]           pin_rise,
  output logic [PIN_WIDTH-1:0]           pin_fall,
  output logic [PIN_WIDTH-1:0]           bbm_busy,
  input  logic [PIN_WIDTH-1:0]           pad_in,
  output logic [PIN_WIDTH-1:0]           pad_out,
  output logic [PIN_WIDTH-1:0]           pad_oe
);

  localparam int MAX_CNT = (FILT_CYCLES > BBM_CYCLES) ? FILT_CYCLES : BBM_CYCLES;
  localparam int CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] BBM_LOAD = (BBM_CYCLES > 0) ? CNT_W'(BBM_CYCLES - 1) : '0;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_BBM = 1'b1
  } bbm_state_e;

  logic [PIN_WIDTH-1:0] pin_lvl;
  logic [PIN_WIDTH-1:0] pin_prev_q;
  logic [PIN_WIDTH-1:0] rise_q;
  logic [PIN_WIDTH-1:0] fall_q;

  // Previous level resets to the pull-up value so reset release makes no edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pin_prev_q <= '1;
      rise_q     <= '0;
      fall_q     <= '0;
    end else begin
      pin_prev_q <= pin_lvl;
      rise_q     <= pin_lvl & ~pin_prev_q;
      fall_q     <= ~pin_lvl & pin_prev_q;
    end
  end

  assign pin_in   = pin_lvl;
  assign pin_rise = rise_q;
  assign pin_fall = fall_q;

  for (genvar i = 0; i < PIN_WIDTH; i++) begin : g_pin
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;

    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in[i]};
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    if (FILT_CYCLES == 0) begin : g_nofilt
      assign pin_lvl[i] = sync_lvl;
    end else begin : g_filt
      localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYCLES - 1);
      logic             filt_q, filt_d;
      logic [CNT_W-1:0] fcnt_q, fcnt_d;

      // Counter restarts on the accepting edge so the next change needs a full run.
      always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_lvl != filt_q) begin
          if (fcnt_q == FILT_LAST) filt_d = sync_lvl;
          else                     fcnt_d = fcnt_q + 1'b1;
        end
      end

      always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
          filt_q <= 1'b1;
          fcnt_q <= '0;
        end else begin
          filt_q <= filt_d;
          fcnt_q <= fcnt_d;
        end
      end

      assign pin_lvl[i] = filt_q;
    end

    logic [3:0] fn_out;
    logic [3:0] fn_oe;
    logic [1:0] sel;

    assign sel       = func_sel[2*i +: 2];
    assign fn_out[0] = gpio_out[i];
    assign fn_oe[0]  = gpio_outen[i];

    for (genvar k = 1; k < 4; k++) begin : g_fn
      if (k <= NUM_ALT) begin : g_alt
        assign fn_out[k] = alt_out[(k-1)*PIN_WIDTH + i];
        assign fn_oe[k]  = alt_outen[(k-1)*PIN_WIDTH + i];
      end else begin : g_park
        assign fn_out[k] = 1'b0;
        assign fn_oe[k]  = 1'b0;
      end
    end

    bbm_state_e       state_q, state_d;
    logic [1:0]       active_q, active_d;
    logic [1:0]       target_q, target_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             out_q, out_d;
    logic             oe_q, oe_d;

    always_comb begin
      state_d  = state_q;
      active_d = active_q;
      target_d = target_q;
      bcnt_d   = bcnt_q;
      out_d    = out_q;
      oe_d     = oe_q;
      case (state_q)
        ST_RUN: begin
          out_d = fn_out[active_q];
          oe_d  = fn_oe[active_q];
          if (sel != active_q) begin
            if (BBM_CYCLES == 0) begin
              active_d = sel;
            end else begin
              state_d  = ST_BBM;
              target_d = sel;
              bcnt_d   = BBM_LOAD;
              out_d    = out_q;
              oe_d     = 1'b0;
            end
          end
        end
        ST_BBM: begin
          oe_d = 1'b0;
          // A new code mid-gap restarts the full gap for the new target.
          if (sel != target_q) begin
            target_d = sel;
            bcnt_d   = BBM_LOAD;
          end else if (bcnt_q == '0) begin
            active_d = target_q;
            state_d  = ST_RUN;
          end else begin
            bcnt_d = bcnt_q - 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
        state_q  <= ST_RUN;
        active_q <= 2'd0;
        target_q <= 2'd0;
        bcnt_q   <= '0;
        out_q    <= 1'b0;
        oe_q     <= 1'b0;
      end else begin
        state_q  <= state_d;
        active_q <= active_d;
        target_q <= target_d;
        bcnt_q   <= bcnt_d;
        out_q    <= out_d;
        oe_q     <= oe_d;
      end
    end

    assign pad_out[i]  = out_q;
    assign pad_oe[i]   = oe_q;
    assign bbm_busy[i] = (state_q == ST_BBM);
  end

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_mcu_pin_mux_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cmsdk_mcu_pin_mux_cfg : three builds of the pin mux against a          |
// | window-based reference model plus directed corner sequences.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_cmsdk_mcu_pin_mux_cfg;
  localparam int W  = 16;
  localparam int ND = 3;
  // Builds: A = defaults, B = 2 alts/no filter/1-cycle gap, C = 1 alt/no gap/long filter
  localparam int P_NA   [ND] = '{3, 2, 1};
  localparam int P_SYNC [ND] = '{2, 3, 4};
  localparam int P_FILT [ND] = '{3, 0, 5};
  localparam int P_BBM  [ND] = '{2, 1, 0};

  logic HCLK = 1'b0;
  logic HRESET = 1'b0;
  logic [2*W-1:0] func_sel;
  logic [W-1:0]   gpio_out, gpio_outen, pad_in;
  logic [3*W-1:0] alt_out, alt_outen;
  logic [ND-1:0][W-1:0] o_pin, o_rise, o_fall, o_busy, o_pout, o_poe;

  always #5 HCLK = ~HCLK;

  cmsdk_mcu_pin_mux_cfg #(.PIN_WIDTH(W), .NUM_ALT(3), .SYNC_STAGES(2), .FILT_CYCLES(3), .BBM_CYCLES(2)) u_dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .func_sel(func_sel), .gpio_out(gpio_out), .gpio_outen(gpio_outen),
    .alt_out(alt_out), .alt_outen(alt_outen), .pin_in(o_pin[0]), .pin_rise(o_rise[0]), .pin_fall(o_fall[0]),
    .bbm_busy(o_busy[0]), .pad_in(pad_in), .pad_out(o_pout[0]), .pad_oe(o_poe[0]));

  cmsdk_mcu_pin_mux_cfg #(.PIN_WIDTH(W), .NUM_ALT(2), .SYNC_STAGES(3), .FILT_CYCLES(0), .BBM_CYCLES(1)) u_dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .func_sel(func_sel), .gpio_out(gpio_out), .gpio_outen(gpio_outen),
    .alt_out(alt_out[2*W-1:0]), .alt_outen(alt_outen[2*W-1:0]), .pin_in(o_pin[1]), .pin_rise(o_rise[1]),
    .pin_fall(o_fall[1]), .bbm_busy(o_busy[1]), .pad_in(pad_in), .pad_out(o_pout[1]), .pad_oe(o_poe[1]));

  cmsdk_mcu_pin_mux_cfg #(.PIN_WIDTH(W), .NUM_ALT(1), .SYNC_STAGES(4), .FILT_CYCLES(5), .BBM_CYCLES(0)) u_dut_c (
    .HCLK(HCLK), .HRESET(HRESET), .func_sel(func_sel), .gpio_out(gpio_out), .gpio_outen(gpio_outen),
    .alt_out(alt_out[W-1:0]), .alt_outen(alt_outen[W-1:0]), .pin_in(o_pin[2]), .pin_rise(o_rise[2]),
    .pin_fall(o_fall[2]), .bbm_busy(o_busy[2]), .pad_in(pad_in), .pad_out(o_pout[2]), .pad_oe(o_poe[2]));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pad delay line, sync-sample history window, gap countdown.
  logic [ND-1:0][W-1:0] m_pin, m_prev, m_rise, m_fall, m_gap, m_out, m_oe;
  logic [3:0] m_padh [ND][W];
  int m_shist [ND][W];
  int m_k     [ND][W];
  int m_act   [ND][W];
  int m_tgt   [ND][W];

  typedef struct {
    logic [W-1:0] g_out;
    logic [W-1:0] g_oe;
    logic [W-1:0] x_out;
    logic [W-1:0] x_oe;
  } vec_t;
  vec_t tbl [4];

  function automatic logic [1:0] m_mux(int d, int code, int i);
    if (code == 0) return {gpio_out[i], gpio_outen[i]};
    if (code <= P_NA[d]) return {alt_out[(code-1)*W + i], alt_outen[(code-1)*W + i]};
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_pin[d] = '1; m_prev[d] = '1; m_rise[d] = '0; m_fall[d] = '0;
      m_gap[d] = '0; m_out[d] = '0; m_oe[d] = '0;
      for (int i = 0; i < W; i++) begin
        m_padh[d][i] = 4'hF; m_shist[d][i] = -1;
        m_k[d][i] = 0; m_act[d][i] = 0; m_tgt[d][i] = 0;
      end
    end
  endtask

  task automatic model_edge();
    logic       old_sync, pin_b;
    logic [1:0] mo;
    int         mask, fs;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < W; i++) begin
        old_sync = m_padh[d][i][P_SYNC[d]-1];
        pin_b = m_pin[d][i];
        m_rise[d][i] = pin_b & ~m_prev[d][i];
        m_fall[d][i] = ~pin_b & m_prev[d][i];
        m_prev[d][i] = pin_b;
        if (P_FILT[d] > 0) begin
          m_shist[d][i] = (m_shist[d][i] << 1) | int'(old_sync);
          mask = (1 << P_FILT[d]) - 1;
          if ((m_shist[d][i] & mask) == (pin_b ? 0 : mask)) m_pin[d][i] = ~pin_b;
        end
        m_padh[d][i] = {m_padh[d][i][2:0], pad_in[i]};
        if (P_FILT[d] == 0) m_pin[d][i] = m_padh[d][i][P_SYNC[d]-1];

        fs = int'(func_sel[2*i +: 2]);
        if (m_gap[d][i]) begin
          m_oe[d][i] = 1'b0;
          if (fs != m_tgt[d][i]) begin
            m_tgt[d][i] = fs; m_k[d][i] = 0;
          end else begin
            m_k[d][i]++;
            if (m_k[d][i] == P_BBM[d]) begin m_gap[d][i] = 1'b0; m_act[d][i] = m_tgt[d][i]; end
          end
        end else if (fs != m_act[d][i]) begin
          if (P_BBM[d] == 0) begin
            mo = m_mux(d, m_act[d][i], i);
            m_out[d][i] = mo[1]; m_oe[d][i] = mo[0];
            m_act[d][i] = fs;
          end else begin
            m_gap[d][i] = 1'b1; m_tgt[d][i] = fs; m_k[d][i] = 0; m_oe[d][i] = 1'b0;
          end
        end else begin
          mo = m_mux(d, m_act[d][i], i);
          m_out[d][i] = mo[1]; m_oe[d][i] = mo[0];
        end
      end
    end
  endtask

  task automatic chk(string nm, int d, logic [W-1:0] got, logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d got=%h expected=%h t=%0t", nm, d, got, exp, $time);
    end
  endtask

  task automatic chk1(string nm, logic got, logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b expected=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    model_edge();
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("pin_in", d, o_pin[d], m_pin[d]);
      chk("pin_rise", d, o_rise[d], m_rise[d]);
      chk("pin_fall", d, o_fall[d], m_fall[d]);
      chk("bbm_busy", d, o_busy[d], m_gap[d]);
      chk("pad_out", d, o_pout[d], m_out[d]);
      chk("pad_oe", d, o_poe[d], m_oe[d]);
    end
  endtask

  task automatic settle(int n);
    repeat (n) step();
  endtask

  // Reset asserted between edges; outputs must respond without a clock.
  task automatic do_reset();
    #2;
    HRESET = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_pin_in", d, o_pin[d], '1);
      chk("rst_pad_oe", d, o_poe[d], '0);
      chk("rst_pad_out", d, o_pout[d], '0);
      chk("rst_bbm_busy", d, o_busy[d], '0);
      chk("rst_rise", d, o_rise[d], '0);
      chk("rst_fall", d, o_fall[d], '0);
    end
    model_reset();
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  initial begin
    func_sel = '0; gpio_out = '0; gpio_outen = '0; alt_out = '0; alt_outen = '0; pad_in = '1;
    tbl[0] = '{16'h00A5, 16'h00FF, 16'h00A5, 16'h00FF};
    tbl[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    tbl[2] = '{16'h1234, 16'hF0F0, 16'h1234, 16'hF0F0};
    tbl[3] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    model_reset();
    do_reset();
    settle(4);

    // GPIO path vectors, alt inputs scrambled to show they are ignored
    for (int t = 0; t < 4; t++) begin
      gpio_out = tbl[t].g_out; gpio_outen = tbl[t].g_oe;
      alt_out = {16'($urandom), $urandom}; alt_outen = {16'($urandom), $urandom};
      step();
      chk("tbl_pad_out", 0, o_pout[0], tbl[t].x_out);
      chk("tbl_pad_oe", 0, o_poe[0], tbl[t].x_oe);
    end

    // Filter latency and glitch rejection on pin 0
    pad_in = '1; settle(12);
    pad_in[0] = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 4) chk1("t2_pin_hold", o_pin[0][0], 1'b1);
      if (c == 5) chk1("t2_pin_low", o_pin[0][0], 1'b0);
      if (c == 6) chk1("t2_fall", o_fall[0][0], 1'b1);
      if (c == 7) chk1("t2_fall_end", o_fall[0][0], 1'b0);
    end
    pad_in[0] = 1'b1; settle(12);
    pad_in[0] = 1'b0; step(); step();
    pad_in[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk1("t2_glitch_pin", o_pin[0][0], 1'b1);
      chk1("t2_glitch_fall", o_fall[0][0], 1'b0);
    end

    // Break-before-make on pin 1: GPIO driving 1 -> alt1 driving 0
    gpio_out = '0; gpio_outen = '0; alt_out = '0; alt_outen = '0; func_sel = '0;
    gpio_out[1] = 1'b1; gpio_outen[1] = 1'b1; alt_outen[1] = 1'b1;
    settle(12);
    chk1("t4_pre_oe", o_poe[0][1], 1'b1);
    func_sel[3:2] = 2'd1;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk1("t4_gap_oe", o_poe[0][1], 1'b0);
      chk1("t4_gap_out_held", o_pout[0][1], 1'b1);
      chk1("t4_gap_busy", o_busy[0][1], c < 3);
      chk1("t5_nogap_oe", o_poe[2][1], 1'b1);
    end
    step();
    chk1("t4_new_oe", o_poe[0][1], 1'b1);
    chk1("t4_new_out", o_pout[0][1], 1'b0);

    // Re-select during the gap on pin 2 restarts the full gap
    gpio_outen[2] = 1'b1; alt_out[2] = 1'b1; alt_outen[2] = 1'b1; alt_outen[W+2] = 1'b1;
    settle(12);
    func_sel[5:4] = 2'd2;
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) func_sel[5:4] = 2'd1;
      step();
      chk1("t5_busy", o_busy[0][2], c <= 4);
      chk1("t5_oe", o_poe[0][2], c == 6);
    end
    chk1("t5_out", o_pout[0][2], 1'b1);

    // Park code on the two-alt build; input path stays live
    gpio_out[3] = 1'b1; gpio_outen[3] = 1'b1; pad_in[3] = 1'b1;
    settle(12);
    chk1("t6_pre_out", o_pout[1][3], 1'b1);
    func_sel[7:6] = 2'd3; pad_in[3] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk1("t6_oe", o_poe[1][3], 1'b0);
      chk1("t6_out", o_pout[1][3], c <= 2);
      chk1("t6_busy", o_busy[1][3], c == 1);
      chk1("t6_pin_in", o_pin[1][3], c < 3);
    end

    // Reset landing inside a gap
    func_sel = ~func_sel;
    step();
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      pad_in = pad_in ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 5) == 0) func_sel = func_sel ^ ($urandom & $urandom);
      gpio_out = 16'($urandom); gpio_outen = 16'($urandom);
      alt_out = {16'($urandom), $urandom}; alt_outen = {16'($urandom), $urandom};
      step();
      if (n == 1500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
